// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_BE_W       = DEF_DATA_W / 8;
    localparam int DEF_STARVE_MAX = 4;
    localparam int STARVE_CNT_W   = 4;
    localparam int PERF_W         = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles in which fetch asked but was denied;
// raises force_if once the count reaches STARVE_MAX.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_reg;
    logic [STARVE_CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!if_req || if_gnt) begin
            cnt_next = '0;
        end else if (cnt_reg != MAX_CNT) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign force_if = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Optional ARB_PERF_EN adds saturating conflict/grant counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                stall_if,
`ifdef ARB_PERF_EN
    output logic [PERF_W-1:0]   perf_conflicts,
    output logic [PERF_W-1:0]   perf_if_grants,
    output logic [PERF_W-1:0]   perf_dm_grants,
`endif
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    logic   force_if;
    owner_t owner_reg;
    owner_t owner_next;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if)
    );

    // Data side wins unless it is idle or fetch has hit its starvation limit.
    always_comb begin
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        owner_next = OWN_NONE;
        if (if_req && (force_if || !dm_req)) begin
            if_gnt     = 1'b1;
            owner_next = OWN_IF;
        end else if (dm_req) begin
            dm_gnt     = 1'b1;
            owner_next = OWN_DM;
        end
    end

    assign stall_if = if_req & ~if_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_be    = {BE_W{1'b1}};
            mem_addr  = if_addr;
        end
    end

    // Owner of the access in flight; the memory answers one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg <= OWN_NONE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    assign if_valid = (owner_reg == OWN_IF);
    assign dm_valid = (owner_reg == OWN_DM);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = dm_valid ? mem_rdata : '0;

`ifdef ARB_PERF_EN
    logic [2:0] perf_inc;
    assign perf_inc = {dm_gnt, if_gnt, if_req & dm_req};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [PERF_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg <= '0;
            end else if (perf_inc[gi] && (cnt_reg != {PERF_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign perf_conflicts = g_perf[0].cnt_reg;
    assign perf_if_grants = g_perf[1].cnt_reg;
    assign perf_dm_grants = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_MAX=4 and STARVE_MAX=1 instances).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;

    logic        if_gnt, if_valid, dm_gnt, dm_valid, stall_if;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;

    logic        s1_if_gnt, s1_if_valid, s1_dm_gnt, s1_dm_valid, s1_stall_if;
    logic [31:0] s1_if_rdata, s1_dm_rdata;
    logic        s1_mem_en, s1_mem_we;
    logic [3:0]  s1_mem_be;
    logic [31:0] s1_mem_addr, s1_mem_wdata;

`ifdef ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_if_grants, perf_dm_grants;
    logic [31:0] s1_perf_conflicts, s1_perf_if_grants, s1_perf_dm_grants;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .stall_if(stall_if),
`ifdef ARB_PERF_EN
        .perf_conflicts(perf_conflicts), .perf_if_grants(perf_if_grants),
        .perf_dm_grants(perf_dm_grants),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(s1_if_gnt),
        .if_valid(s1_if_valid), .if_rdata(s1_if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(s1_dm_gnt), .dm_valid(s1_dm_valid), .dm_rdata(s1_dm_rdata),
        .stall_if(s1_stall_if),
`ifdef ARB_PERF_EN
        .perf_conflicts(s1_perf_conflicts), .perf_if_grants(s1_perf_if_grants),
        .perf_dm_grants(s1_perf_dm_grants),
`endif
        .mem_en(s1_mem_en), .mem_we(s1_mem_we), .mem_be(s1_mem_be), .mem_addr(s1_mem_addr),
        .mem_wdata(s1_mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_be = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = 32'h1234_5678;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_dm_valid", 32'(dm_valid), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        $display("txn reset: if_valid=%0b dm_valid=%0b", if_valid, dm_valid);
        @(negedge clk); rst = 1'b1;

        // Fetch only
        if_req = 1'b1; if_addr = 32'h10; #1;
        check("if_only_gnt", 32'(if_gnt), 32'd1);
        check("if_only_stall", 32'(stall_if), 32'd0);
        check("if_only_mem_we", 32'(mem_we), 32'd0);
        check("if_only_mem_be", 32'(mem_be), 32'hF);
        check("if_only_mem_addr", mem_addr, 32'h10);
        @(negedge clk); if_req = 1'b0; mem_rdata = 32'h0050_0093; #1;
        check("if_only_valid", 32'(if_valid), 32'd1);
        check("if_only_rdata", if_rdata, 32'h0050_0093);
        check("if_only_dm_valid", 32'(dm_valid), 32'd0);
        $display("txn fetch 0x10: if_valid=%0b if_rdata=0x%08h", if_valid, if_rdata);

        // Store only
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h204;
        dm_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h0; #1;
        check("st_dm_gnt", 32'(dm_gnt), 32'd1);
        check("st_if_gnt", 32'(if_gnt), 32'd0);
        check("st_mem_en", 32'(mem_en), 32'd1);
        check("st_mem_we", 32'(mem_we), 32'd1);
        check("st_mem_be", 32'(mem_be), 32'h3);
        check("st_mem_addr", mem_addr, 32'h204);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk); dm_req = 1'b0; dm_we = 1'b0; #1;
        check("st_dm_valid", 32'(dm_valid), 32'd1);
        check("st_if_valid", 32'(if_valid), 32'd0);
        $display("txn store 0x204: dm_valid=%0b", dm_valid);

        // Clean counters/state, then continuous dual requests
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_addr = 32'h100; dm_be = 4'hF;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("dual%0d_if_gnt", c), 32'(if_gnt), (c % 5 == 4) ? 32'd1 : 32'd0);
            check($sformatf("dual%0d_dm_gnt", c), 32'(dm_gnt), (c % 5 == 4) ? 32'd0 : 32'd1);
            check($sformatf("dual%0d_stall", c), 32'(stall_if), (c % 5 == 4) ? 32'd0 : 32'd1);
            check($sformatf("dual%0d_s1_if_gnt", c), 32'(s1_if_gnt), (c % 2 == 1) ? 32'd1 : 32'd0);
            $display("txn dual cycle %0d: if_gnt=%0b dm_gnt=%0b s1_if_gnt=%0b", c, if_gnt, dm_gnt, s1_if_gnt);
            @(negedge clk);
        end
`ifdef ARB_PERF_EN
        #1;
        check("perf_conflicts", perf_conflicts, 32'd10);
        check("perf_dm_grants", perf_dm_grants, 32'd8);
        check("perf_if_grants", perf_if_grants, 32'd2);
`endif

        // Back-to-back dm load then fetch: data returned in grant order
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; #1;
        check("ld_dm_gnt", 32'(dm_gnt), 32'd1);
        check("ld_mem_addr", mem_addr, 32'h300);
        @(negedge clk);
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h14; mem_rdata = 32'hAAAA_0001; #1;
        check("alt_if_gnt", 32'(if_gnt), 32'd1);
        check("alt_mem_addr", mem_addr, 32'h14);
        check("alt_dm_valid", 32'(dm_valid), 32'd1);
        check("alt_dm_rdata", dm_rdata, 32'hAAAA_0001);
        check("alt_if_valid0", 32'(if_valid), 32'd0);
        check("alt_if_rdata0", if_rdata, 32'd0);
        $display("txn load 0x300: dm_valid=%0b dm_rdata=0x%08h", dm_valid, dm_rdata);
        @(negedge clk); if_req = 1'b0; mem_rdata = 32'hBBBB_0002; #1;
        check("alt_if_valid", 32'(if_valid), 32'd1);
        check("alt_if_rdata", if_rdata, 32'hBBBB_0002);
        check("alt_dm_valid0", 32'(dm_valid), 32'd0);
        check("alt_dm_rdata0", dm_rdata, 32'd0);
        $display("txn fetch 0x14: if_valid=%0b if_rdata=0x%08h", if_valid, if_rdata);

        // Build up starvation, then reset during the in-flight dm load
        @(negedge clk); if_req = 1'b1; dm_req = 1'b1; #1;
        check("pre_rst_dm_gnt0", 32'(dm_gnt), 32'd1);
        @(negedge clk); #1;
        check("pre_rst_dm_gnt1", 32'(dm_gnt), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_rdata = 32'hCCCC_0003; #1;
        check("midrst_dm_valid", 32'(dm_valid), 32'd0);
        check("midrst_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("post_rst_dm_valid", 32'(dm_valid), 32'd0);
        check("post_rst_if_valid", 32'(if_valid), 32'd0);
        $display("txn reset mid-access: dm_valid=%0b", dm_valid);
        @(negedge clk); #1;
        check("post_rst_dm_valid2", 32'(dm_valid), 32'd0);
        if_req = 1'b1; dm_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("post_rst%0d_if_gnt", c), 32'(if_gnt), (c == 4) ? 32'd1 : 32'd0);
            $display("txn post-reset dual cycle %0d: if_gnt=%0b", c, if_gnt);
            @(negedge clk);
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
